// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and defaults for the fetch sequencer.
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;
  localparam int PC_W_DEF  = 8;
  localparam int CNT_W_DEF = 32;
  localparam int RESET_PC  = 0;
endpackage

// File: rtl/fetch_sequencer_sat_counter.sv
// sat_counter: clearable up-counter that sticks at its maximum value.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] count_q;
  always_ff @(posedge clk) begin
    if (rst || clr) count_q <= '0;
    else if (inc && count_q != '1) count_q <= count_q + WIDTH'(1);
  end
  assign count = count_q;
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC and sequences instruction fetch from start to halt.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             f_clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  start_addr,
  input  logic             imem_ready,
  input  logic             halt,
  input  logic             branch,
  input  logic             taken,
  input  logic [PC_W-1:0]  target,
  output logic [PC_W-1:0]  pc_o,
  output logic             fetch_req,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] stall_count
);
  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            fetch, accept;
  assign fetch  = state_q == FETCH;
  assign accept = fetch && imem_ready;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (start) begin
      state_d = FETCH;
      pc_d    = start_addr;
    end else if (accept) begin
      state_d = halt ? DONE : FETCH;
      pc_d    = halt ? pc_q : (branch && taken) ? target : pc_q + PC_W'(1);
    end
  end
  always_ff @(posedge f_clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= PC_W'(RESET_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end
  assign pc_o      = pc_q;
  assign fetch_req = fetch;
  assign done      = state_q == DONE;
  // Clear outranks increment, so a start in FETCH zeroes the counters.
  sat_counter #(.WIDTH(CNT_W)) u_cycle (
    .clk(f_clk), .rst(reset), .clr(start), .inc(fetch), .count(cycle_count)
  );
  sat_counter #(.WIDTH(CNT_W)) u_instr (
    .clk(f_clk), .rst(reset), .clr(start), .inc(accept), .count(instr_count)
  );
  sat_counter #(.WIDTH(CNT_W)) u_stall (
    .clk(f_clk), .rst(reset), .clr(start), .inc(fetch && !imem_ready), .count(stall_count)
  );
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and random checks against a behavioural model.
module tb_fetch_sequencer;
  localparam int CW  = 5;
  localparam int MAX = (1 << CW) - 1;
  logic          f_clk = 0, reset, start, imem_ready, halt, branch, taken;
  logic [7:0]    start_addr, target, pc_o;
  logic          fetch_req, done;
  logic [CW-1:0] cycle_count, instr_count, stall_count;
  int n_chk = 0, n_fail = 0;
  bit m_run, m_done;
  int m_pc, m_cyc, m_ins, m_stl;

  fetch_sequencer #(.PC_W(8), .CNT_W(CW)) dut (
    .f_clk(f_clk), .reset(reset), .start(start), .start_addr(start_addr),
    .imem_ready(imem_ready), .halt(halt), .branch(branch), .taken(taken),
    .target(target), .pc_o(pc_o), .fetch_req(fetch_req), .done(done),
    .cycle_count(cycle_count), .instr_count(instr_count), .stall_count(stall_count)
  );

  always #5 f_clk = ~f_clk;

  task automatic step(input bit rs, input bit st, input int sa, input bit rdy,
                      input bit h, input bit br, input bit tk, input int tg);
    reset = rs; start = st; start_addr = 8'(sa); imem_ready = rdy;
    halt = h; branch = br; taken = tk; target = 8'(tg);
    @(posedge f_clk);
    if (rs) begin
      m_run = 0; m_done = 0; m_pc = 0; m_cyc = 0; m_ins = 0; m_stl = 0;
    end else if (st) begin
      m_run = 1; m_done = 0; m_pc = sa & 255; m_cyc = 0; m_ins = 0; m_stl = 0;
    end else if (m_run) begin
      if (m_cyc < MAX) m_cyc++;
      if (!rdy) begin
        if (m_stl < MAX) m_stl++;
      end else begin
        if (m_ins < MAX) m_ins++;
        if (h) begin m_run = 0; m_done = 1; end
        else if (br && tk) m_pc = tg & 255;
        else m_pc = (m_pc + 1) % 256;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    n_chk++;
    if ({pc_o, fetch_req, done, cycle_count, instr_count, stall_count} !== '0) begin
      n_fail++;
      $display("FAIL reset: pc=%h req=%b done=%b cyc=%0d ins=%0d stl=%0d, want all 0",
               pc_o, fetch_req, done, cycle_count, instr_count, stall_count);
    end
  endtask

  task automatic test_basic_run();
    step(0, 1, 'h10, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (pc_o !== 8'(16 + i) || fetch_req !== 1'b1) begin
        n_fail++; $display("FAIL basic_pc%0d: pc=%h req=%b, want %h req=1", i, pc_o, fetch_req, 16 + i);
      end
      step(0, 0, 0, 1, 0, 0, 0, 0);
    end
    step(0, 0, 0, 1, 1, 0, 0, 0);
    n_chk++;
    if (done !== 1'b1 || fetch_req !== 1'b0 || pc_o !== 8'h13 || instr_count !== 4 ||
        cycle_count !== 4 || stall_count !== 0) begin
      n_fail++;
      $display("FAIL basic_halt: done=%b req=%b pc=%h ins=%0d cyc=%0d stl=%0d, want 1 0 13 4 4 0",
               done, fetch_req, pc_o, instr_count, cycle_count, stall_count);
    end
  endtask

  task automatic test_branch();
    step(0, 1, 'h10, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 1, 'h40);
    n_chk++;
    if (pc_o !== 8'h40) begin n_fail++; $display("FAIL branch_taken: pc=%h want 40", pc_o); end
    step(0, 1, 'h12, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 1, 0, 'h40);
    n_chk++;
    if (pc_o !== 8'h13) begin n_fail++; $display("FAIL branch_not_taken: pc=%h want 13", pc_o); end
    step(0, 0, 0, 0, 1, 1, 1, 'h77);
    n_chk++;
    if (pc_o !== 8'h13 || fetch_req !== 1'b1) begin
      n_fail++; $display("FAIL branch_stalled: pc=%h req=%b want 13 1", pc_o, fetch_req);
    end
  endtask

  task automatic test_stall();
    step(0, 1, 'h10, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    n_chk++;
    if (pc_o !== 8'h11 || stall_count !== 3 || cycle_count !== 4 || instr_count !== 1) begin
      n_fail++;
      $display("FAIL stall: pc=%h stl=%0d cyc=%0d ins=%0d want 11 3 4 1",
               pc_o, stall_count, cycle_count, instr_count);
    end
    step(0, 0, 0, 1, 0, 0, 0, 0);
    n_chk++;
    if (pc_o !== 8'h12) begin n_fail++; $display("FAIL stall_resume: pc=%h want 12", pc_o); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc [4];
    exp_pc = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    step(0, 1, 'hFE, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (pc_o !== exp_pc[i]) begin
        n_fail++; $display("FAIL wrap%0d: pc=%h want %h", i, pc_o, exp_pc[i]);
      end
      step(0, 0, 0, 1, 0, 0, 0, 0);
    end
  endtask

  task automatic test_midrun();
    step(0, 1, 'h30, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 'h80, 1, 1, 1, 1, 'h55);
    n_chk++;
    if (pc_o !== 8'h80 || fetch_req !== 1'b1 || done !== 1'b0 ||
        {cycle_count, instr_count, stall_count} !== '0) begin
      n_fail++;
      $display("FAIL midrun_start: pc=%h req=%b cyc=%0d ins=%0d stl=%0d want 80 1 0 0 0",
               pc_o, fetch_req, cycle_count, instr_count, stall_count);
    end
    step(0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 1, 'h44, 1, 0, 0, 0, 0);
    n_chk++;
    if (pc_o !== 8'h00 || fetch_req !== 1'b0 || done !== 1'b0 ||
        {cycle_count, instr_count, stall_count} !== '0) begin
      n_fail++;
      $display("FAIL midrun_reset: pc=%h req=%b done=%b cyc=%0d ins=%0d stl=%0d want all 0",
               pc_o, fetch_req, done, cycle_count, instr_count, stall_count);
    end
    step(0, 0, 0, 1, 1, 1, 1, 'h99);
    n_chk++;
    if (pc_o !== 8'h00 || fetch_req !== 1'b0 || cycle_count !== 0) begin
      n_fail++; $display("FAIL idle_hold: pc=%h req=%b cyc=%0d want 00 0 0", pc_o, fetch_req, cycle_count);
    end
  endtask

  task automatic test_halt_priority();
    step(0, 1, 'h20, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1, 1, 'h50);
    n_chk++;
    if (done !== 1'b1 || pc_o !== 8'h20 || fetch_req !== 1'b0) begin
      n_fail++; $display("FAIL halt_wins: done=%b pc=%h req=%b want 1 20 0", done, pc_o, fetch_req);
    end
    step(0, 0, 0, 1, 0, 1, 1, 'h50);
    n_chk++;
    if (done !== 1'b1 || pc_o !== 8'h20 || cycle_count !== 1 || instr_count !== 1) begin
      n_fail++;
      $display("FAIL done_frozen: done=%b pc=%h cyc=%0d ins=%0d want 1 20 1 1",
               done, pc_o, cycle_count, instr_count);
    end
    step(0, 1, 'h05, 0, 0, 0, 0, 0);
    n_chk++;
    if (done !== 1'b0 || fetch_req !== 1'b1 || pc_o !== 8'h05 || cycle_count !== 0) begin
      n_fail++;
      $display("FAIL restart_from_done: done=%b req=%b pc=%h cyc=%0d want 0 1 05 0",
               done, fetch_req, pc_o, cycle_count);
    end
  endtask

  task automatic test_saturation();
    step(0, 1, 'h00, 0, 0, 0, 0, 0);
    for (int i = 0; i < MAX + 8; i++) step(0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < MAX + 8; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    n_chk++;
    if (cycle_count !== CW'(MAX) || instr_count !== CW'(MAX) || stall_count !== CW'(MAX)) begin
      n_fail++;
      $display("FAIL saturate: cyc=%0d ins=%0d stl=%0d want %0d each",
               cycle_count, instr_count, stall_count, MAX);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(99) < 2, $urandom_range(99) < 6, int'($urandom_range(255)),
           $urandom_range(99) < 70, $urandom_range(99) < 8, $urandom_range(1),
           $urandom_range(1), int'($urandom_range(255)));
      n_chk++;
      if (pc_o !== 8'(m_pc) || fetch_req !== m_run || done !== m_done ||
          cycle_count !== CW'(m_cyc) || instr_count !== CW'(m_ins) || stall_count !== CW'(m_stl)) begin
        n_fail++;
        $display("FAIL random%0d: pc=%h req=%b done=%b cyc=%0d ins=%0d stl=%0d want %h %b %b %0d %0d %0d",
                 i, pc_o, fetch_req, done, cycle_count, instr_count, stall_count,
                 m_pc, m_run, m_done, m_cyc, m_ins, m_stl);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_branch();
    test_stall();
    test_wrap();
    test_midrun();
    test_halt_priority();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
